// File: rtl/cl_axil_pkg.sv
// Shared types and constants for the CL AXI4-Lite register master.
package cl_axil_pkg;

  localparam int unsigned AXIL_DATA_W     = 32;
  localparam int unsigned AXIL_STRB_W     = AXIL_DATA_W / 8;
  // Widest address the captured-command register can hold; ADDR_W must not exceed it.
  localparam int unsigned AXIL_ADDR_W_MAX = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } axil_mst_state_t;

  typedef struct packed {
    logic                       rnw;
    logic [AXIL_ADDR_W_MAX-1:0] addr;
    logic [AXIL_DATA_W-1:0]     wdata;
    logic [AXIL_STRB_W-1:0]     wstrb;
  } axil_cmd_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] rdata;
    logic [1:0]             resp;
    logic                   timeout;
  } axil_rsp_t;

  // Response reported when the watchdog aborts a transaction.
  function automatic axil_rsp_t timeout_rsp();
    timeout_rsp = '{rdata: '0, resp: RESP_SLVERR, timeout: 1'b1};
  endfunction

  // Response register contents out of reset.
  function automatic axil_rsp_t idle_rsp();
    idle_rsp = '{rdata: '0, resp: RESP_OKAY, timeout: 1'b0};
  endfunction

endpackage

// File: rtl/cl_axil_master_if.sv
// Command/response stream plus AXI4-Lite master bus for cl_axil_master.
interface cl_axil_master_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import cl_axil_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_rnw;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [AXIL_DATA_W-1:0] cmd_wdata;
  logic [AXIL_STRB_W-1:0] cmd_wstrb;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [AXIL_DATA_W-1:0] rsp_rdata;
  logic [1:0]             rsp_resp;
  logic                   rsp_timeout;

  logic                   m_awvalid;
  logic                   m_awready;
  logic [ADDR_W-1:0]      m_awaddr;
  logic                   m_wvalid;
  logic                   m_wready;
  logic [AXIL_DATA_W-1:0] m_wdata;
  logic [AXIL_STRB_W-1:0] m_wstrb;
  logic                   m_bvalid;
  logic                   m_bready;
  logic [1:0]             m_bresp;
  logic                   m_arvalid;
  logic                   m_arready;
  logic [ADDR_W-1:0]      m_araddr;
  logic                   m_rvalid;
  logic                   m_rready;
  logic [AXIL_DATA_W-1:0] m_rdata;
  logic [1:0]             m_rresp;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp,
    input  m_arready, m_rvalid, m_rdata, m_rresp
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp,
    output m_arready, m_rvalid, m_rdata, m_rresp
  );

endinterface

// File: rtl/cl_axil_wdog.sv
// Per-phase watchdog: counts cycles while enabled, flags the last allowed cycle.
module cl_axil_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_main_a0,
  input  logic rst_main_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic           WDOG_ON  = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q;

  // Cycle counter; clear has priority so a new phase always starts from zero.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Expiry is combinational so the FSM can abort on the same edge.
  assign expire_c_o = WDOG_ON && en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/cl_axil_master.sv
// Single-outstanding AXI4-Lite master driven by a command/response stream.
module cl_axil_master
  import cl_axil_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               clk_main_a0,
  input logic               rst_main_n,
  cl_axil_master_if.master  bus
);

  axil_mst_state_t state_q;
  axil_cmd_t       cmd_q;
  axil_rsp_t       rsp_q;
  logic            cmd_ready_q, rsp_valid_q;
  logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic            aw_done_q, w_done_q;

  logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c, wr_done_c;
  logic wait_c, leave_c, expire_c;
  logic unused_cmd_c;

  assign aw_hs_c   = awvalid_q & bus.m_awready;
  assign w_hs_c    = wvalid_q  & bus.m_wready;
  assign b_hs_c    = bready_q  & bus.m_bvalid;
  assign ar_hs_c   = arvalid_q & bus.m_arready;
  assign r_hs_c    = rready_q  & bus.m_rvalid;
  assign wr_done_c = (aw_done_q | aw_hs_c) & (w_done_q | w_hs_c);

  // Bits of the captured command that only serve as storage width headroom.
  assign unused_cmd_c = ^{cmd_q.rnw, cmd_q.addr};

  // Watchdog enable and the "phase ends this cycle" strobe that clears it.
  always_comb begin
    wait_c  = 1'b0;
    leave_c = 1'b0;
    unique case (state_q)
      ST_WR_REQ:  begin wait_c = 1'b1; leave_c = wr_done_c; end
      ST_WR_RESP: begin wait_c = 1'b1; leave_c = b_hs_c;    end
      ST_RD_REQ:  begin wait_c = 1'b1; leave_c = ar_hs_c;   end
      ST_RD_RESP: begin wait_c = 1'b1; leave_c = r_hs_c;    end
      default:    begin wait_c = 1'b0; leave_c = 1'b0;      end
    endcase
    leave_c = leave_c | expire_c;
  end

  cl_axil_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .clr_i       (leave_c | ~wait_c),
    .en_i        (wait_c),
    .expire_c_o  (expire_c)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rsp_q       <= idle_rsp();
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_ready_q && bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            cmd_q       <= '{rnw:   bus.cmd_rnw,
                             addr:  AXIL_ADDR_W_MAX'(bus.cmd_addr),
                             wdata: bus.cmd_wdata,
                             wstrb: bus.cmd_wstrb};
            if (bus.cmd_rnw) begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_WR_REQ;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs_c) begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
          if (w_hs_c)  begin wvalid_q  <= 1'b0; w_done_q  <= 1'b1; end
          if (wr_done_c) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end else if (expire_c) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rsp_q       <= timeout_rsp();
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_WR_RESP: begin
          if (b_hs_c) begin
            bready_q    <= 1'b0;
            rsp_q       <= '{rdata: '0, resp: bus.m_bresp, timeout: 1'b0};
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end else if (expire_c) begin
            bready_q    <= 1'b0;
            rsp_q       <= timeout_rsp();
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (ar_hs_c) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end else if (expire_c) begin
            arvalid_q   <= 1'b0;
            rsp_q       <= timeout_rsp();
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RD_RESP: begin
          if (r_hs_c) begin
            rready_q    <= 1'b0;
            rsp_q       <= '{rdata: bus.m_rdata, resp: bus.m_rresp, timeout: 1'b0};
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end else if (expire_c) begin
            rready_q    <= 1'b0;
            rsp_q       <= timeout_rsp();
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_q.rdata;
  assign bus.rsp_resp    = rsp_q.resp;
  assign bus.rsp_timeout = rsp_q.timeout;

  assign bus.m_awvalid = awvalid_q;
  assign bus.m_awaddr  = ADDR_W'(cmd_q.addr);
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_wdata   = cmd_q.wdata;
  assign bus.m_wstrb   = cmd_q.wstrb;
  assign bus.m_bready  = bready_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_araddr  = ADDR_W'(cmd_q.addr);
  assign bus.m_rready  = rready_q;

endmodule

// File: tb/tb_cl_axil_master.sv
// Directed bench for cl_axil_master with a hand-driven AXI-L slave.
module tb_cl_axil_master;

  logic clk_main_a0;
  logic rst_main_n;
  int   checks;
  int   errors;

  cl_axil_master_if #(.ADDR_W(32)) bus ();

  cl_axil_master #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .bus         (bus)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  // Advance n clocks and land 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_main_a0);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic rnw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.cmd_valid = 1'b1;
    bus.cmd_rnw   = rnw;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_main_a0 = 1'b0;
    rst_main_n  = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0;
    bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;    bus.m_rresp = 2'b00;

    // Reset values
    step(3);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_valids", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 64'd0);
    check("rst_readies", 64'({bus.m_bready, bus.m_rready}), 64'd0);
    check("rst_awaddr", 64'(bus.m_awaddr), 64'd0);
    rst_main_n = 1'b1;
    step(1);
    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // 1: zero-wait write
    send_cmd(1'b0, 32'h500, 32'hDEADBEEF, 4'hF);
    bus.m_awready = 1'b1; bus.m_wready = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    check("t1_aw_w_valid", 64'({bus.m_awvalid, bus.m_wvalid}), 64'h3);
    check("t1_awaddr", 64'(bus.m_awaddr), 64'h500);
    check("t1_wdata", 64'(bus.m_wdata), 64'hDEADBEEF);
    check("t1_wstrb", 64'(bus.m_wstrb), 64'hF);
    check("t1_cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
    step(1);
    bus.m_awready = 1'b0; bus.m_wready = 1'b0;
    check("t1_aw_w_dropped", 64'({bus.m_awvalid, bus.m_wvalid}), 64'h0);
    check("t1_bready", 64'(bus.m_bready), 64'd1);
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    step(1);
    bus.m_bvalid = 1'b0;
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t1_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("t1_rsp_resp", 64'(bus.rsp_resp), 64'd0);
    check("t1_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("t1_bready_dropped", 64'(bus.m_bready), 64'd0);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    check("t1_rsp_done", 64'(bus.rsp_valid), 64'd0);
    check("t1_idle_ready", 64'(bus.cmd_ready), 64'd1);

    // 2: W completes three cycles before AW
    send_cmd(1'b0, 32'h508, 32'h11223344, 4'h3);
    bus.m_wready = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    check("t2_aw_w_valid", 64'({bus.m_awvalid, bus.m_wvalid}), 64'h3);
    step(1);
    bus.m_wready = 1'b0;
    check("t2_w_dropped_aw_held", 64'({bus.m_awvalid, bus.m_wvalid}), 64'h2);
    step(1);
    check("t2_aw_held", 64'({bus.m_awvalid, bus.m_wvalid}), 64'h2);
    check("t2_awaddr_stable", 64'(bus.m_awaddr), 64'h508);
    check("t2_no_bready_yet", 64'(bus.m_bready), 64'd0);
    step(1);
    bus.m_awready = 1'b1;
    check("t2_aw_still_held", 64'(bus.m_awvalid), 64'd1);
    step(1);
    bus.m_awready = 1'b0;
    check("t2_aw_dropped", 64'(bus.m_awvalid), 64'd0);
    check("t2_bready", 64'(bus.m_bready), 64'd1);
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    step(1);
    check("t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t2_single_b", 64'(bus.m_bready), 64'd0);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    check("t2_rsp_done", 64'(bus.rsp_valid), 64'd0);
    check("t2_no_second_b", 64'(bus.m_bready), 64'd0);
    bus.m_bvalid = 1'b0;
    step(1);
    check("t2_single_rsp", 64'(bus.rsp_valid), 64'd0);

    // 3: read with arready low for 5 cycles, SLVERR forwarded
    send_cmd(1'b1, 32'h504, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      bus.cmd_valid = 1'b0;
      check("t3_arvalid_wait", 64'(bus.m_arvalid), 64'd1);
      check("t3_araddr_stable", 64'(bus.m_araddr), 64'h504);
    end
    step(1);
    check("t3_araddr_hs", 64'(bus.m_araddr), 64'h504);
    bus.m_arready = 1'b1;
    step(1);
    bus.m_arready = 1'b0;
    check("t3_ar_dropped", 64'(bus.m_arvalid), 64'd0);
    check("t3_rready", 64'(bus.m_rready), 64'd1);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_1234; bus.m_rresp = 2'b10;
    step(1);
    bus.m_rvalid = 1'b0;
    check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t3_rsp_rdata", 64'(bus.rsp_rdata), 64'h1234);
    check("t3_rsp_resp", 64'(bus.rsp_resp), 64'h2);
    check("t3_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("t3_rready_dropped", 64'(bus.m_rready), 64'd0);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    check("t3_rsp_done", 64'(bus.rsp_valid), 64'd0);

    // 4: arready never comes, watchdog after 16 cycles, then a normal read
    send_cmd(1'b1, 32'h600, 32'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      step(1);
      bus.cmd_valid = 1'b0;
      check("t4_arvalid_held", 64'(bus.m_arvalid), 64'd1);
    end
    step(1);
    check("t4_arvalid_dropped", 64'(bus.m_arvalid), 64'd0);
    check("t4_rready_low", 64'(bus.m_rready), 64'd0);
    check("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t4_rsp_resp", 64'(bus.rsp_resp), 64'h2);
    check("t4_rsp_timeout", 64'(bus.rsp_timeout), 64'd1);
    check("t4_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    check("t4_idle_ready", 64'(bus.cmd_ready), 64'd1);
    send_cmd(1'b1, 32'h504, 32'h0, 4'h0);
    bus.m_arready = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    check("t4b_arvalid", 64'(bus.m_arvalid), 64'd1);
    check("t4b_araddr", 64'(bus.m_araddr), 64'h504);
    step(1);
    bus.m_arready = 1'b0;
    check("t4b_rready", 64'(bus.m_rready), 64'd1);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFEF00D; bus.m_rresp = 2'b00;
    step(1);
    bus.m_rvalid = 1'b0;
    check("t4b_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t4b_rsp_rdata", 64'(bus.rsp_rdata), 64'hCAFEF00D);
    check("t4b_rsp_resp", 64'(bus.rsp_resp), 64'd0);
    check("t4b_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;

    // 5: response backpressure with a second command waiting
    send_cmd(1'b0, 32'h510, 32'hA5A5A5A5, 4'h1);
    bus.m_awready = 1'b1; bus.m_wready = 1'b1;
    step(1);
    send_cmd(1'b1, 32'h514, 32'h0, 4'h0);
    step(1);
    bus.m_awready = 1'b0; bus.m_wready = 1'b0;
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b11;
    step(1);
    bus.m_bvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t5_rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
      check("t5_rsp_resp_stable", 64'(bus.rsp_resp), 64'h3);
      check("t5_rsp_rdata_stable", 64'(bus.rsp_rdata), 64'd0);
      check("t5_cmd_blocked", 64'(bus.cmd_ready), 64'd0);
      step(1);
    end
    check("t5_rsp_valid_hs", 64'(bus.rsp_valid), 64'd1);
    check("t5_no_early_ar", 64'(bus.m_arvalid), 64'd0);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;
    check("t5_rsp_done", 64'(bus.rsp_valid), 64'd0);
    check("t5_idle_ready", 64'(bus.cmd_ready), 64'd1);
    bus.m_arready = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    check("t5_second_ar", 64'(bus.m_arvalid), 64'd1);
    check("t5_second_araddr", 64'(bus.m_araddr), 64'h514);
    check("t5_second_busy", 64'(bus.cmd_ready), 64'd0);
    step(1);
    bus.m_arready = 1'b0;
    check("t5_second_rready", 64'(bus.m_rready), 64'd1);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0000_55AA; bus.m_rresp = 2'b00;
    step(1);
    bus.m_rvalid = 1'b0;
    check("t5_second_rsp", 64'(bus.rsp_valid), 64'd1);
    check("t5_second_rdata", 64'(bus.rsp_rdata), 64'h55AA);
    check("t5_second_timeout", 64'(bus.rsp_timeout), 64'd0);
    bus.rsp_ready = 1'b1;
    step(1);
    bus.rsp_ready = 1'b0;

    // 6: asynchronous reset while waiting for B
    send_cmd(1'b0, 32'h520, 32'h12345678, 4'hF);
    bus.m_awready = 1'b1; bus.m_wready = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    step(1);
    bus.m_awready = 1'b0; bus.m_wready = 1'b0;
    check("t6_in_wr_resp", 64'(bus.m_bready), 64'd1);
    #3;
    rst_main_n = 1'b0;
    #1;
    check("t6_async_bready", 64'(bus.m_bready), 64'd0);
    check("t6_async_valids", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_rready}), 64'd0);
    check("t6_async_cmd_rsp", 64'({bus.cmd_ready, bus.rsp_valid}), 64'd0);
    check("t6_async_awaddr", 64'(bus.m_awaddr), 64'd0);
    check("t6_async_wdata", 64'(bus.m_wdata), 64'd0);
    step(1);
    rst_main_n = 1'b1;
    bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
    step(1);
    check("t6_idle_ready", 64'(bus.cmd_ready), 64'd1);
    check("t6_no_bready", 64'(bus.m_bready), 64'd0);
    check("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
    step(2);
    bus.m_bvalid = 1'b0;
    check("t6_no_spurious_rsp", 64'(bus.rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cl_axil_master.md
Name: cl_axil_master

Overview:
- Single-outstanding AXI4-Lite master (initiator) for CL-internal register traffic.
- Converts a simple command/response stream into AXI-L read or write transactions. It is used to drive OCL-style register slaves from internal logic or test sequencers.
- Includes a per-transaction watchdog that reports hung slaves and returns the block to idle.

Parameters:
- ADDR_W, 32, address width of cmd_addr and m_awaddr/m_araddr.
- TIMEOUT_CYCLES, 1024, cycles allowed per AXI phase before abort; 0 disables the watchdog.

Ports:
- clk_main_a0  in  1  clock
- rst_main_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  AXI bresp/rresp, or 2'b10 on timeout
- rsp_timeout  out  1  transaction aborted by the watchdog
- m_awvalid/m_awaddr[ADDR_W]  out; m_awready  in
- m_wvalid/m_wdata[32]/m_wstrb[4]  out; m_wready  in
- m_bvalid  in; m_bresp[2]  in; m_bready  out
- m_arvalid/m_araddr[ADDR_W]  out; m_arready  in
- m_rvalid  in; m_rdata[32]  in; m_rresp[2]  in; m_rready  out

Behaviour:
- Reset: rst_main_n asynchronous, active-low, clock clk_main_a0. During reset all outputs are 0, the state is IDLE and the timeout counter is 0.
- States:
  - IDLE
  - WR_REQ (AW and W outstanding)
  - WR_RESP
  - RD_REQ
  - RD_RESP
  - RSP
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On handshake, register addr/wdata/wstrb. Go to WR_REQ (m_awvalid = m_wvalid = 1 next cycle) or RD_REQ (m_arvalid = 1 next cycle).
- WR_REQ:
  - AW and W complete independently. Each valid drops in the cycle after its own handshake, tracked by aw_done/w_done flags.
  - A same-cycle AW+W handshake is legal.
  - Move to WR_RESP once both are done.
- WR_RESP:
  - m_bready = 1.
  - On m_bvalid, capture bresp and set rsp_rdata = 0. Go to RSP.
- RD_REQ: m_arvalid held until m_arready, then go to RD_RESP.
- RD_RESP:
  - m_rready = 1.
  - On m_rvalid, capture rdata/rresp. Go to RSP.
- RSP:
  - rsp_valid = 1, with data stable until rsp_ready.
  - Return to IDLE the cycle after the handshake. A new cmd can be accepted in that IDLE cycle.
- Address/data/strobe outputs are stable while their valid is high. Valids never depend combinationally on readies.
- Minimum latency, zero-wait slave:
  - write: cmd handshake cycle 0, AW/W cycle 1, B cycle 2, rsp_valid cycle 3;
  - read: cmd cycle 0, AR cycle 1, R cycle 2, rsp_valid cycle 3.
- Watchdog:
  - The counter clears on every state change and increments in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - When the count reaches TIMEOUT_CYCLES-1 with the awaited handshake still absent, all m_* valids and readies drop next cycle.
  - The block enters RSP with rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
  - A handshake occurring in the expiry cycle wins, and no timeout is reported.
  - The watchdog does not run in RSP (consumer backpressure is unbounded).
- Reset mid-transaction: immediate abort to IDLE with all outputs 0. No response is produced.
- Read data is passed unmodified. Non-OKAY resp is forwarded with rsp_timeout = 0.

Decomposition:
- cl_axil_pkg:
  - state enum axil_mst_state_t;
  - resp constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - struct axil_cmd_t {rnw, addr, wdata, wstrb};
  - struct axil_rsp_t {rdata, resp, timeout}.
- One natural sub-module, cl_axil_wdog: a counter with clear/enable/expire, parameterised by TIMEOUT_CYCLES.
- Everything else stays in cl_axil_master.

Test Plan:
1. Write cmd addr 0x500, wdata 0xDEADBEEF, wstrb 0xF, zero-wait slave -> AW/W asserted cycle 1 with those values; rsp_valid cycle 3, rsp_resp 0, rsp_rdata 0, rsp_timeout 0.
2. Slave asserts m_wready 3 cycles before m_awready -> m_wvalid drops after its handshake while m_awvalid is held; exactly one B accepted; single response.
3. Read addr 0x504, slave returns 0x0000_1234 with rresp 2'b10 after 5 cycles of arready low -> m_araddr stable throughout; rsp_rdata 0x1234, rsp_resp 2'b10, rsp_timeout 0.
4. TIMEOUT_CYCLES = 16, slave never asserts m_arready -> m_arvalid drops after 16 cycles; rsp_resp 2'b10, rsp_timeout 1; next command executes normally.
5. rsp_ready held low 10 cycles with a second cmd_valid pending -> rsp fields stable, cmd_ready 0; second cmd accepted the cycle after the rsp handshake.
6. Assert rst_main_n low while in WR_RESP -> all outputs 0 asynchronously; state IDLE after release; no spurious rsp_valid.
